mul32_seq: RTL



---
 rtl/mul32_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mul32_seq.sv
// mul32_seq: sequential 32x32->64 multiplier for the MULT/MULTU path.
// One 32-bit add per cycle (radix-2 shift-add) over 32 CALC cycles, then a
// FIX cycle that applies the result sign and loads HI/LO. Signed operands
// are reduced to magnitudes so the datapath itself is always unsigned.
module mul32_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Magnitude of a 32-bit two's-complement value; 0x80000000 maps to itself
   // when read as unsigned, which is exactly the magnitude we need.
   function automatic logic [31:0] mag32(input logic [31:0] v);
      logic [31:0] r;
      if (v[31]) begin
         r = ~v + 32'd1;
      end else begin
         r = v;
      end
      return r;
   endfunction

   state_t      state_q, state_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic [31:0] acc_q, acc_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        neg_q, neg_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [32:0] sum_s;
   logic [63:0] prod_s;
   logic [63:0] prod_neg_s;

   // Next-state and datapath: shift-add step, sign fix-up and handshake flags.
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      hi_d     = hi_q;
      lo_d     = lo_q;

      // The single 32-bit adder; carry-out becomes bit 63 of the working pair.
      if (mplier_q[0]) begin
         sum_s = {1'b0, acc_q} + {1'b0, mcand_q};
      end else begin
         sum_s = {1'b0, acc_q};
      end
      prod_s     = {acc_q, mplier_q};
      prod_neg_s = ~prod_s + 64'd1;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               mcand_d  = is_signed ? mag32(a) : a;
               mplier_d = is_signed ? mag32(b) : b;
               neg_d    = is_signed & (a[31] ^ b[31]);
               acc_d    = 32'd0;
               cnt_d    = 5'd0;
               busy_d   = 1'b1;
               state_d  = S_CALC;
            end else begin
               busy_d   = 1'b0;
               state_d  = S_IDLE;
            end
         end
         S_CALC: begin
            // 65-bit right shift of {carry, sum, mplier}; low bit drops out.
            {acc_d, mplier_d} = {sum_s, mplier_q[31:1]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = S_FIX;
            end else begin
               state_d = S_CALC;
            end
         end
         S_FIX: begin
            if (neg_q) begin
               {hi_d, lo_d} = prod_neg_s;
            end else begin
               {hi_d, lo_d} = prod_s;
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State, working registers and registered outputs; reset aborts any op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         mcand_q  <= 32'd0;
         mplier_q <= 32'd0;
         acc_q    <= 32'd0;
         cnt_q    <= 5'd0;
         neg_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
